// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Control FSM for a multicycle RV32I(+M) core. It sequences fetch, decode,
// execute, memory and writeback over one shared memory port.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   opcode, funct7_b0 fields of the current instruction register
//   branch_taken      compare result for the current branch
//   mem_ready         memory access completes this cycle
//   mul_done          mul/div result valid
//   pc_wen, ir_wen    PC / IR (+old PC) write enables
//   adr_src           memory address select (0 PC, 1 ALU-out register)
//   mem_req, mem_wen  memory request / write
//   imm_control       immediate format (000 I, 001 S, 010 B, 011 U, 100 J)
//   alu_src_a_sel     00 PC, 01 old PC, 10 rs1, 11 zero
//   alu_src_b_sel     00 rs2, 01 immediate, 10 constant 4
//   alu_op            00 add, 01 branch compare, 10 R funct, 11 I funct
//   result_sel        00 ALU-out reg, 01 mem data, 10 live ALU, 11 mul/div
//   gpr_wen           register-file write
//   mul_start         one-cycle start pulse to the mul/div unit
//   illegal_instr     sticky illegal-instruction flag
//   bus_error         sticky memory-timeout flag
//   state_o           low four bits of the current state (TRAP reads as 0,
//                     like IDLE; the sticky flags tell the two apart)
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter bit          ENABLE_M       = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 32'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       funct7_b0,
  input  logic       branch_taken,
  input  logic       mem_ready,
  input  logic       mul_done,
  output logic       pc_wen,
  output logic       ir_wen,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_wen,
  output logic [2:0] imm_control,
  output logic [1:0] alu_src_a_sel,
  output logic [1:0] alu_src_b_sel,
  output logic [1:0] alu_op,
  output logic [1:0] result_sel,
  output logic       gpr_wen,
  output logic       mul_start,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [3:0] state_o
);

  typedef enum logic [4:0] {
    S_IDLE      = 5'd0,
    S_FETCH     = 5'd1,
    S_DECODE    = 5'd2,
    S_MEM_ADR   = 5'd3,
    S_MEM_READ  = 5'd4,
    S_MEM_WB    = 5'd5,
    S_MEM_WRITE = 5'd6,
    S_EXEC_R    = 5'd7,
    S_EXEC_I    = 5'd8,
    S_EXEC_U    = 5'd9,
    S_ALU_WB    = 5'd10,
    S_BRANCH    = 5'd11,
    S_JAL       = 5'd12,
    S_JALR      = 5'd13,
    S_JALR_LINK = 5'd14,
    S_MUL_WAIT  = 5'd15,
    S_TRAP      = 5'd16
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bus_error_q, bus_error_d;
  logic   timeout_hit;

  // Memory-wait watchdog: counts stalled cycles in a memory-wait state and
  // fires when the count has reached the limit and ready is still low.
  generate
    if (TIMEOUT_CYCLES > 32'd0) begin : g_timeout
      localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 32'd1);
      logic [TW-1:0] cnt_q, cnt_d;
      logic          in_mem_wait;

      assign in_mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                           (state_q == S_MEM_WRITE);
      assign timeout_hit = in_mem_wait && !mem_ready && (cnt_q == TW'(TIMEOUT_CYCLES));

      // Next stall count; any exit from a wait state (or leaving it) clears it.
      always_comb begin
        cnt_d = '0;
        if (in_mem_wait && !mem_ready && !timeout_hit) begin
          cnt_d = cnt_q + TW'(1);
        end else begin
          cnt_d = '0;
        end
      end

      // Stall counter register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // State and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Next-state logic; ready wins over a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R: begin
            if (!funct7_b0) begin
              state_d = S_EXEC_R;
            end else if (ENABLE_M) begin
              state_d = S_MUL_WAIT;
            end else begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          end
          OP_I:             state_d = S_EXEC_I;
          OP_LUI, OP_AUIPC: state_d = S_EXEC_U;
          OP_BRANCH:        state_d = S_BRANCH;
          OP_JAL:           state_d = S_JAL;
          OP_JALR:          state_d = S_JALR;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        if (opcode == OP_STORE) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_MEM_WB:    state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_EXEC_U:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_JALR_LINK;
      S_JALR:      state_d = S_JALR_LINK;
      S_JALR_LINK: state_d = S_ALU_WB;
      S_MUL_WAIT: begin
        if (mul_done) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MUL_WAIT;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath control decode of the current state.
  always_comb begin
    pc_wen        = 1'b0;
    ir_wen        = 1'b0;
    adr_src       = 1'b0;
    mem_req       = 1'b0;
    mem_wen       = 1'b0;
    imm_control   = 3'b000;
    alu_src_a_sel = 2'b00;
    alu_src_b_sel = 2'b00;
    alu_op        = 2'b00;
    result_sel    = 2'b00;
    gpr_wen       = 1'b0;
    mul_start     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req       = 1'b1;
        alu_src_b_sel = 2'b10;
        result_sel    = 2'b10;
        pc_wen        = mem_ready;
        ir_wen        = mem_ready;
      end
      S_DECODE: begin
        // Speculatively forms the B-type target; JAL redoes it with J-type.
        alu_src_a_sel = 2'b01;
        alu_src_b_sel = 2'b01;
        imm_control   = 3'b010;
        mul_start     = ENABLE_M && (opcode == OP_R) && funct7_b0;
      end
      S_MEM_ADR: begin
        alu_src_a_sel = 2'b10;
        alu_src_b_sel = 2'b01;
        imm_control   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        result_sel = 2'b01;
        gpr_wen    = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_wen = 1'b1;
        adr_src = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_sel = 2'b10;
        alu_op        = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a_sel = 2'b10;
        alu_src_b_sel = 2'b01;
        alu_op        = 2'b11;
      end
      S_EXEC_U: begin
        imm_control   = 3'b011;
        alu_src_b_sel = 2'b01;
        alu_src_a_sel = (opcode == OP_LUI) ? 2'b11 : 2'b01;
      end
      S_ALU_WB: begin
        gpr_wen = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_sel = 2'b10;
        alu_op        = 2'b01;
        pc_wen        = branch_taken;
      end
      S_JAL: begin
        alu_src_a_sel = 2'b01;
        alu_src_b_sel = 2'b01;
        imm_control   = 3'b100;
        result_sel    = 2'b10;
        pc_wen        = 1'b1;
      end
      S_JALR: begin
        alu_src_a_sel = 2'b10;
        alu_src_b_sel = 2'b01;
        result_sel    = 2'b10;
        pc_wen        = 1'b1;
      end
      S_JALR_LINK: begin
        // Link value old PC + 4 lands in ALU-out, written back by ALU_WB.
        alu_src_a_sel = 2'b01;
        alu_src_b_sel = 2'b10;
      end
      S_MUL_WAIT: begin
        result_sel = 2'b11;
        gpr_wen    = mul_done;
      end
      default: begin
        pc_wen = 1'b0;
      end
    endcase
  end

  assign illegal_instr = illegal_q;
  assign bus_error     = bus_error_q;
  assign state_o       = state_q[3:0];

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Two controllers share one stimulus stream: A with ENABLE_M=1 and a 4-cycle
// bus timeout, B with default parameters. A per-instruction step-list model
// predicts every output of both on every cycle; literal expectations pin the
// key cases (reset, fetch, decode, mul wait, traps).
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, funct7_b0, branch_taken, mem_ready, mul_done;
  logic [6:0] opcode;

  logic       a_pc_wen, a_ir_wen, a_adr_src, a_mem_req, a_mem_wen, a_gpr_wen, a_mul_start, a_ill, a_berr;
  logic [2:0] a_imm;
  logic [1:0] a_asel, a_bsel, a_alu_op, a_rsel;
  logic [3:0] a_state;
  logic       b_pc_wen, b_ir_wen, b_adr_src, b_mem_req, b_mem_wen, b_gpr_wen, b_mul_start, b_ill, b_berr;
  logic [2:0] b_imm;
  logic [1:0] b_asel, b_bsel, b_alu_op, b_rsel;
  logic [3:0] b_state;

  multicycle_controller #(.ENABLE_M(1'b1), .TIMEOUT_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_b0(funct7_b0),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mul_done(mul_done),
    .pc_wen(a_pc_wen), .ir_wen(a_ir_wen), .adr_src(a_adr_src), .mem_req(a_mem_req),
    .mem_wen(a_mem_wen), .imm_control(a_imm), .alu_src_a_sel(a_asel),
    .alu_src_b_sel(a_bsel), .alu_op(a_alu_op), .result_sel(a_rsel),
    .gpr_wen(a_gpr_wen), .mul_start(a_mul_start), .illegal_instr(a_ill),
    .bus_error(a_berr), .state_o(a_state));

  multicycle_controller dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_b0(funct7_b0),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mul_done(mul_done),
    .pc_wen(b_pc_wen), .ir_wen(b_ir_wen), .adr_src(b_adr_src), .mem_req(b_mem_req),
    .mem_wen(b_mem_wen), .imm_control(b_imm), .alu_src_a_sel(b_asel),
    .alu_src_b_sel(b_bsel), .alu_op(b_alu_op), .result_sel(b_rsel),
    .gpr_wen(b_gpr_wen), .mul_start(b_mul_start), .illegal_instr(b_ill),
    .bus_error(b_berr), .state_o(b_state));

  // {pc,ir,adr,req,wen,imm[3],a[2],b[2],alu[2],res[2],gpr,mstart,ill,berr,state[4]}
  logic [23:0] vec_a, vec_b;
  assign vec_a = {a_pc_wen, a_ir_wen, a_adr_src, a_mem_req, a_mem_wen, a_imm, a_asel, a_bsel,
                  a_alu_op, a_rsel, a_gpr_wen, a_mul_start, a_ill, a_berr, a_state};
  assign vec_b = {b_pc_wen, b_ir_wen, b_adr_src, b_mem_req, b_mem_wen, b_imm, b_asel, b_bsel,
                  b_alu_op, b_rsel, b_gpr_wen, b_mul_start, b_ill, b_berr, b_state};

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  // Model: each instruction is a fetch, a decode and a short list of steps.
  typedef enum int {M_IDLE, M_TRAP, M_F, M_D, M_ADR, M_LD, M_LDWB, M_ST, M_XR, M_XI,
                    M_XU, M_WB, M_BR, M_JAL, M_JALR, M_LINK, M_MUL} mstep_t;
  mstep_t cur  [2];
  mstep_t plan [2][3];
  int     plen [2];
  int     pidx [2];
  int     wcnt [2];
  bit     ill  [2];
  bit     berr [2];

  function automatic int tmo(int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic bit enm(int k);
    return (k == 0);
  endfunction

  // Debug code: position of the state in the listed state order, TRAP shows 0.
  function automatic logic [3:0] dbg(mstep_t s);
    case (s)
      M_F: return 4'd1;      M_D: return 4'd2;     M_ADR: return 4'd3;  M_LD: return 4'd4;
      M_LDWB: return 4'd5;   M_ST: return 4'd6;    M_XR: return 4'd7;   M_XI: return 4'd8;
      M_XU: return 4'd9;     M_WB: return 4'd10;   M_BR: return 4'd11;  M_JAL: return 4'd12;
      M_JALR: return 4'd13;  M_LINK: return 4'd14; M_MUL: return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [23:0] m_out(int k);
    logic pc, ir, adr, req, wen, gpr, ms;
    logic [2:0] imm;
    logic [1:0] a, b, alu, rs;
    {pc, ir, adr, req, wen, gpr, ms} = 7'b0;
    imm = 3'b000; a = 2'b00; b = 2'b00; alu = 2'b00; rs = 2'b00;
    case (cur[k])
      M_F:    begin req = 1'b1; b = 2'b10; rs = 2'b10; pc = mem_ready; ir = mem_ready; end
      M_D:    begin a = 2'b01; b = 2'b01; imm = 3'b010;
                    ms = enm(k) && (opcode == OP_R) && funct7_b0; end
      M_ADR:  begin a = 2'b10; b = 2'b01; imm = (opcode == OP_STORE) ? 3'b001 : 3'b000; end
      M_LD:   begin req = 1'b1; adr = 1'b1; end
      M_LDWB: begin rs = 2'b01; gpr = 1'b1; end
      M_ST:   begin req = 1'b1; wen = 1'b1; adr = 1'b1; end
      M_XR:   begin a = 2'b10; alu = 2'b10; end
      M_XI:   begin a = 2'b10; b = 2'b01; alu = 2'b11; end
      M_XU:   begin imm = 3'b011; b = 2'b01; a = (opcode == OP_LUI) ? 2'b11 : 2'b01; end
      M_WB:   begin gpr = 1'b1; end
      M_BR:   begin a = 2'b10; alu = 2'b01; pc = branch_taken; end
      M_JAL:  begin a = 2'b01; b = 2'b01; imm = 3'b100; rs = 2'b10; pc = 1'b1; end
      M_JALR: begin a = 2'b10; b = 2'b01; rs = 2'b10; pc = 1'b1; end
      M_LINK: begin a = 2'b01; b = 2'b10; end
      M_MUL:  begin rs = 2'b11; gpr = mul_done; end
      default: ;
    endcase
    return {pc, ir, adr, req, wen, imm, a, b, alu, rs, gpr, ms, ill[k], berr[k], dbg(cur[k])};
  endfunction

  task automatic set_plan(int k, int n, mstep_t s0, mstep_t s1, mstep_t s2);
    plan[k][0] = s0; plan[k][1] = s1; plan[k][2] = s2; plen[k] = n;
  endtask

  task automatic advance(int k);
    wcnt[k] = 0;
    if (pidx[k] < plen[k]) begin
      cur[k] = plan[k][pidx[k]];
      pidx[k]++;
    end else begin
      cur[k] = M_F;
    end
  endtask

  task automatic m_decode(int k);
    bit bad = 1'b0;
    case (opcode)
      OP_LOAD:          set_plan(k, 3, M_ADR, M_LD, M_LDWB);
      OP_STORE:         set_plan(k, 2, M_ADR, M_ST, M_WB);
      OP_R: begin
        if (!funct7_b0)  set_plan(k, 2, M_XR, M_WB, M_WB);
        else if (enm(k)) set_plan(k, 1, M_MUL, M_WB, M_WB);
        else             bad = 1'b1;
      end
      OP_I:             set_plan(k, 2, M_XI, M_WB, M_WB);
      OP_LUI, OP_AUIPC: set_plan(k, 2, M_XU, M_WB, M_WB);
      OP_BRANCH:        set_plan(k, 1, M_BR, M_WB, M_WB);
      OP_JAL:           set_plan(k, 3, M_JAL, M_LINK, M_WB);
      OP_JALR:          set_plan(k, 3, M_JALR, M_LINK, M_WB);
      default:          bad = 1'b1;
    endcase
    if (bad) begin
      cur[k] = M_TRAP; ill[k] = 1'b1;
    end else begin
      pidx[k] = 0;
      advance(k);
    end
  endtask

  // Advance model k across one clock edge, using the inputs of the ending cycle.
  task automatic m_step(int k);
    if (!rst_n) begin
      cur[k] = M_IDLE; ill[k] = 1'b0; berr[k] = 1'b0; wcnt[k] = 0; plen[k] = 0; pidx[k] = 0;
    end else begin
      case (cur[k])
        M_IDLE: begin cur[k] = M_F; wcnt[k] = 0; end
        M_TRAP: ;
        M_F, M_LD, M_ST: begin
          if (mem_ready) begin
            if (cur[k] == M_F) begin cur[k] = M_D; wcnt[k] = 0; end
            else advance(k);
          end else if (tmo(k) != 0 && wcnt[k] == tmo(k)) begin
            cur[k] = M_TRAP; berr[k] = 1'b1;
          end else begin
            wcnt[k]++;
          end
        end
        M_MUL: if (mul_done) advance(k);
        M_D: m_decode(k);
        default: advance(k);
      endcase
    end
  endtask

  task automatic chk(string name, logic [23:0] act, logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both controllers against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_a", vec_a, m_out(0));
      chk("model_b", vec_b, m_out(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    if (cur[0] == M_F || cur[0] == M_IDLE) begin
      case ($urandom_range(0, 8))
        0: opcode = OP_LOAD;   1: opcode = OP_STORE;  2: opcode = OP_R;
        3: opcode = OP_I;      4: opcode = OP_LUI;    5: opcode = OP_AUIPC;
        6: opcode = OP_BRANCH; 7: opcode = OP_JAL;    default: opcode = OP_JALR;
      endcase
      funct7_b0 = (opcode == OP_R) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    // Ready is forced on the last cycle before A's timeout would fire.
    mem_ready    = ($urandom_range(0, 2) != 0) || (wcnt[0] == 4);
    mul_done     = 1'($urandom_range(0, 1));
    branch_taken = 1'($urandom_range(0, 1));
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; opcode = 7'b0; funct7_b0 = 1'b0; branch_taken = 1'b0;
    mem_ready = 1'b0; mul_done = 1'b0;
    tick();
    chk_on = 1'b1;
    settle();
    chk("reset_a", vec_a, 24'h000000);
    chk("reset_b", vec_b, 24'h000000);

    // Random legal instruction stream, variable memory latency.
    rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      tick();
    end

    // Mul/div: A runs it, B (no M) traps as illegal.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; mem_ready = 1'b1; mul_done = 1'b0; opcode = OP_R; funct7_b0 = 1'b1;
    tick();
    settle(); chk("fetch_ready_a", vec_a, 24'hD02201);
    tick();
    settle(); chk("decode_mul_a", vec_a, 24'h025042); chk("decode_mul_b", vec_b, 24'h025002);
    tick();
    settle(); chk("mul_wait_a", vec_a, 24'h00030F); chk("trap_ill_b", vec_b, 24'h000020);
    repeat (2) tick();
    mul_done = 1'b1;
    settle(); chk("mul_done_a", vec_a, 24'h00038F);
    tick();
    mul_done = 1'b0; mem_ready = 1'b0;
    repeat (3) tick();
    settle(); chk("ill_sticky_b", vec_b, 24'h000020);
    rst_n = 1'b0; tick();
    settle(); chk("ill_cleared_b", vec_b, 24'h000000);

    // Fetch stalls forever: A traps after five FETCH cycles, B keeps waiting.
    rst_n = 1'b1; mem_ready = 1'b0; funct7_b0 = 1'b0;
    tick(); repeat (4) tick();
    settle(); chk("fetch_wait5_a", vec_a, 24'h102201);
    tick();
    settle(); chk("timeout_trap_a", vec_a, 24'h000010); chk("no_timeout_b", vec_b, 24'h102201);
    repeat (4) tick();

    // Ready on the fifth FETCH cycle: no trap.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; mem_ready = 1'b0;
    tick(); repeat (4) tick();
    mem_ready = 1'b1;
    tick();
    settle(); chk("ready5_decode_a", vec_a, 24'h025002);
    repeat (3) tick();

    // Unknown opcode traps both.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; mem_ready = 1'b1; opcode = 7'b1111111;
    repeat (3) tick();
    settle(); chk("illegal_a", vec_a, 24'h000020); chk("illegal_b", vec_b, 24'h000020);
    repeat (4) tick();

    // Reset in the middle of a load read drops the request immediately.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      rand_inputs();
      if (cur[0] == M_LD) found = 1'b1;
      else tick();
    end
    if (!found) begin
      n_checks++; n_errors++;
      $display("FAIL find_load: no load read reached within cycle budget");
    end else begin
      rst_n = 1'b0; tick();
      settle(); chk("midaccess_reset_a", vec_a, 24'h000000);
      rst_n = 1'b1;
    end

    // A second random stretch after all the directed traffic.
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      tick();
    end

    rst_n = 1'b0; tick(); tick();
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multicycle RV32I(+optional M) core. It sequences fetch, decode, execute, memory and writeback over a shared memory port. It drives the same datapath control fields the single-cycle decoder produces, plus PC/IR write enables and a memory req/ready handshake. Multiplier/divider support and a bus-timeout trap are parameter-selectable.

Parameters:
ENABLE_M, 0, 1 = route R-type with funct7[0]=1 to the external mul/div unit; 0 = treat it as illegal.
TIMEOUT_CYCLES, 0, maximum wait cycles per memory access before a bus-error trap; 0 disables the timeout.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
opcode  input  7  IR[6:0]
funct7_b0  input  1  IR[25]
branch_taken  input  1  branch comparison result for the current instruction, from the ALU/compare unit
mem_ready  input  1  memory access completes this cycle
mul_done  input  1  mul/div result valid
pc_wen  output  1  PC register write
ir_wen  output  1  IR and old-PC register write
adr_src  output  1  memory address select: 0 = PC, 1 = ALU-out register
mem_req  output  1  memory request
mem_wen  output  1  memory write
imm_control  output  3  000 I, 001 S, 010 B, 011 U, 100 J
alu_src_a_sel  output  2  00 PC, 01 old PC, 10 rs1 register, 11 zero
alu_src_b_sel  output  2  00 rs2 register, 01 immediate, 10 constant 4
alu_op  output  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
result_sel  output  2  00 ALU-out register, 01 memory data, 10 live ALU result, 11 mul/div result
gpr_wen  output  1  register-file write
mul_start  output  1  one-cycle start pulse to the mul/div unit
illegal_instr  output  1  sticky illegal-opcode flag
bus_error  output  1  sticky memory-timeout flag
state_o  output  4  current state, for debug

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, EXEC_U, ALU_WB, BRANCH, JAL, JALR, JALR_LINK, MUL_WAIT, TRAP.
- Outputs are a Moore decode of the state, except that pc_wen, ir_wen and the exit from wait states are qualified by inputs as listed below.
- Every output not listed for a state is 0.
- Reset: from the first clk edge with rst_n=0, state=IDLE and illegal_instr=bus_error=0. IDLE drives all outputs 0.
- IDLE -> FETCH on the first edge with rst_n=1.
- Reset asserted mid-access drops mem_req at that edge; no handshake completion is required.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_sel=10.
  - ir_wen=pc_wen=mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE on mem_ready.
- DECODE: a=01, b=01, imm=010, alu_op=00 (branch/JAL target into ALU-out).
  - Next state by opcode:
    - 0000011 / 0100011 -> MEM_ADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0110111 / 0010111 -> EXEC_U
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - anything else -> TRAP
  - 0110011 with funct7_b0=1: when ENABLE_M=1, mul_start=1 and next state is MUL_WAIT; when ENABLE_M=0, next state is TRAP.
  - JAL: the target immediate must be J type. JAL therefore recomputes the target in its own state.
- MEM_ADR: a=10, b=01, alu_op=00, imm=000 (load) or 001 (store). Load -> MEM_READ; store -> MEM_WRITE.
- MEM_READ: mem_req=1, adr_src=1. Wait for mem_ready, then -> MEM_WB.
- MEM_WB: result_sel=01, gpr_wen=1 -> FETCH.
- MEM_WRITE: mem_req=1, mem_wen=1, adr_src=1. Wait for mem_ready, then -> FETCH.
- During any wait, mem_req, mem_wen and adr_src are held stable.
- EXEC_R: a=10, b=00, alu_op=10 -> ALU_WB.
- EXEC_I: a=10, b=01, imm=000, alu_op=11 -> ALU_WB.
- EXEC_U: imm=011, b=01, alu_op=00; a=11 for LUI, a=01 for AUIPC -> ALU_WB.
- ALU_WB: result_sel=00, gpr_wen=1 -> FETCH.
- MUL_WAIT: result_sel=11, gpr_wen=mul_done. Exit to FETCH on mul_done. mul_start is never reasserted while waiting.
- BRANCH: a=10, b=00, alu_op=01, result_sel=00, pc_wen=branch_taken -> FETCH.
- JAL: a=01, b=01, imm=100, result_sel=10, pc_wen=1 -> JALR_LINK.
- JALR: a=10, b=01, imm=000, alu_op=00, result_sel=10, pc_wen=1 -> JALR_LINK.
- JALR_LINK: a=01, b=10, alu_op=00 -> ALU_WB (rd = old PC + 4). rs1 is taken from the register latched in DECODE, so rd==rs1 is safe.
- TRAP: terminal until reset; no writes and no requests.
  - illegal_instr is set on entry from DECODE.
  - bus_error is set on entry from a timeout.
- Timeout: a counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to FETCH, MEM_READ and MEM_WRITE and increments each cycle without mem_ready.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0 -> TRAP.
  - mem_ready in that same cycle takes priority over the timeout.
  - Logic is absent when TIMEOUT_CYCLES=0.
- Latency with zero-wait memory: ALU ops 4 cycles, load 5, store 4, branch 3, JAL/JALR 5, mul/div 3 + wait.

Test Plan:
- Reset, then add with mem_ready tied 1 -> states IDLE, FETCH, DECODE, EXEC_R, ALU_WB, FETCH; gpr_wen=1 only in ALU_WB; result_sel=00.
- Load with mem_ready delayed 3 cycles in MEM_READ -> mem_req and adr_src=1 held for 4 cycles; MEM_WB asserts result_sel=01 and gpr_wen=1 exactly once.
- Branch with branch_taken=0, then branch_taken=1 -> pc_wen is 0 and 1 respectively in BRANCH; return to FETCH after 3 cycles.
- JALR -> pc_wen=1 with a=10 and b=01; then JALR_LINK a=01, b=10; then ALU_WB gpr_wen=1.
- ENABLE_M=1, R-type with funct7_b0=1 -> mul_start pulse exactly 1 cycle; gpr_wen low until mul_done; with ENABLE_M=0 the same instruction gives TRAP and illegal_instr=1, sticky until rst_n=0.
- TIMEOUT_CYCLES=4 with mem_ready stuck 0 in FETCH -> TRAP after 5 cycles in FETCH, bus_error=1, mem_req=0.
- TIMEOUT_CYCLES=4 with ready on the 5th cycle -> no trap.
